// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped write-through cache slice.
package cache_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 10;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int LINES   = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL
  } state_t;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [DATA_W-1:0]  word_t;

endpackage

// File: rtl/main_memory.sv
// Single-port backing RAM: synchronous write, registered synchronous read.
module main_memory #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents start at zero so never-written addresses read back as 0.
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, write-allocate cache (one word per line)
// in front of an internal main memory; read results are held on `out`.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int DATA_W  = cache_pkg::DATA_W,
  parameter int INDEX_W = cache_pkg::INDEX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic              R_W,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_data;
  logic                req_rw;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_array  [LINES];
  logic [DATA_W-1:0]   data_array [LINES];

  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic                accept;

  logic                line_we;
  logic [DATA_W-1:0]   line_wdata;
  logic                out_we;
  logic [DATA_W-1:0]   out_wdata;
  logic                mem_we;
  logic                mem_re;
  logic [DATA_W-1:0]   mem_rdata;

  assign req_index = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
  assign hit       = valid_q[req_index] && (tag_array[req_index] == req_tag);
  assign accept    = (state_q == IDLE) && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ready) state_d = LOOKUP;
      LOOKUP:  state_d = (!req_rw && !hit) ? FILL : IDLE;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_we    = 1'b0;
    line_wdata = req_data;
    out_we     = 1'b0;
    out_wdata  = mem_rdata;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (req_rw) begin
          line_we = 1'b1;
          mem_we  = 1'b1;
        end else if (hit) begin
          out_we    = 1'b1;
          out_wdata = data_array[req_index];
        end else begin
          mem_re = 1'b1;
        end
      end
      FILL: begin
        line_we    = 1'b1;
        line_wdata = mem_rdata;
        out_we     = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture only in IDLE; inputs are ignored while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= address;
      req_data <= data;
      req_rw   <= R_W;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_array[req_index]  <= req_tag;
      data_array[req_index] <= line_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      out     <= '0;
    end else begin
      if (line_we) valid_q[req_index] <= 1'b1;
      if (out_we)  out <= out_wdata;
    end
  end

  main_memory #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (req_addr),
    .wdata (req_data),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a reference memory/cache model and scoreboard queue.
module tb_cache_controller;
  import cache_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic       R_W;
  logic [9:0] address;
  logic [9:0] data;
  logic [9:0] out;

  int total = 0;
  int bad   = 0;

  logic [9:0] mdl_mem   [1024];
  logic       mdl_valid [16];
  logic [5:0] mdl_tag   [16];
  logic [9:0] exp_q [$];

  cache_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ready   (ready),
    .R_W     (R_W),
    .address (address),
    .data    (data),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    total++;
    assert (dut.state_q === IDLE) else begin
      bad++;
      $error("FAIL %s observed_state=%0d expected_state=%0d", tag, dut.state_q, IDLE);
    end
  endtask

  task automatic mdl_write(input logic [9:0] a, input logic [9:0] d);
    mdl_mem[a]         = d;
    mdl_valid[a[3:0]]  = 1'b1;
    mdl_tag[a[3:0]]    = a[9:4];
  endtask

  task automatic mdl_read(input logic [9:0] a, output logic [9:0] e, output logic h);
    h = mdl_valid[a[3:0]] && (mdl_tag[a[3:0]] == a[9:4]);
    e = mdl_mem[a];
    mdl_valid[a[3:0]] = 1'b1;
    mdl_tag[a[3:0]]   = a[9:4];
  endtask

  // One request with ready held for a single accepting edge.
  task automatic op(input logic rw, input logic [9:0] a, input logic [9:0] d, input string tag);
    logic [9:0] prev, e;
    logic       h;
    @(negedge clk);
    R_W = rw; address = a; data = d; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    prev  = out;
    if (rw) begin
      mdl_write(a, d);
      @(posedge clk); #1;
      chk({tag, "_out_hold"}, out, prev);
    end else begin
      mdl_read(a, e, h);
      exp_q.push_back(e);
      if (!h) begin
        @(posedge clk); #1;
        chk({tag, "_miss_wait"}, out, prev);
      end
      @(posedge clk); #1;
      chk(tag, out, exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] e, held;
    logic       h;
    for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_tag[i]   = '0;
    end
    rst_n = 1'b0; ready = 1'b0; R_W = 1'b0; address = '0; data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("reset_idle_out%0d", i), out, 10'h000);
    end
    chk_idle("reset_idle_state");

    // Abort a read miss while in FILL.
    @(negedge clk);
    R_W = 1'b0; address = 10'h3F7; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", out, 10'h000);
    chk_idle("abort_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_after", out, 10'h000);
    chk_idle("abort_state_after");

    op(1'b1, 10'h002, 10'h0C3, "wr_002");
    op(1'b1, 10'h2A5, 10'h025, "wr_2A5");
    op(1'b0, 10'h002, 10'h000, "rd_002_hit");
    op(1'b0, 10'h2A5, 10'h000, "rd_2A5_hit");

    op(1'b1, 10'h1A9, 10'h26E, "wr_1A9");
    op(1'b0, 10'h1A9, 10'h000, "rd_1A9_hit");

    op(1'b1, 10'h02C, 10'h3FF, "wr_02C");
    op(1'b0, 10'h02D, 10'h000, "rd_02D_cold");
    op(1'b0, 10'h02C, 10'h000, "rd_02C_hit");

    op(1'b1, 10'h2A5, 10'h025, "wr_2A5_again");
    op(1'b1, 10'h0A5, 10'h111, "wr_0A5_evict");
    op(1'b0, 10'h2A5, 10'h000, "rd_2A5_conflict");
    op(1'b0, 10'h0A5, 10'h000, "rd_0A5_conflict");

    // Hold a read with ready high for 8 cycles.
    @(negedge clk);
    R_W = 1'b0; address = 10'h2A5; ready = 1'b1;
    mdl_read(10'h2A5, e, h);
    exp_q.push_back(e);
    repeat (3) @(negedge clk);
    held = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_rd_2A5_%0d", i), out, held);
    end
    ready = 1'b0;
    op(1'b0, 10'h0A5, 10'h000, "rd_0A5_after_hold");

    // Address change during FILL is ignored.
    @(negedge clk);
    R_W = 1'b0; address = 10'h2A5; ready = 1'b1;
    mdl_read(10'h2A5, e, h);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    address = 10'h002;
    @(posedge clk); #1;
    held = exp_q.pop_front();
    chk("fill_ignore_change", out, held);
    @(negedge clk);
    ready = 1'b0;
    @(posedge clk); #1;
    chk("fill_ignore_after", out, held);
    chk_idle("fill_ignore_state");

    op(1'b0, 10'h002, 10'h000, "rd_002_final");

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
